// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pool controller and its datapath.
package maxpool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_e;

  // Widest supported datapath; narrower users shift this down to their width.
  localparam int MAXW = 64;
  localparam logic [MAXW-1:0] MOST_NEG_MAXW = {1'b1, {(MAXW-1){1'b0}}};

endpackage

// File: rtl/maxpool_ctrl_if.sv
// Element stream into the max-pool controller (valid/ready handshake).
interface maxpool_ctrl_if #(
  parameter int N = 32
);
  logic signed [N-1:0] in_data;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/maxpool.sv
// Running-maximum datapath: clear to zero, load, or keep the larger value.
module maxpool #(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic signed [N-1:0] dp_I,
  input  logic                max_clr,
  input  logic                max_pool,
  output logic signed [N-1:0] dp_O
);

  logic signed [N-1:0] max_q;

  always_ff @(posedge clk) begin
    if (max_clr) begin
      max_q <= '0;
    end else if (!max_pool) begin
      max_q <= dp_I;
    end else if (dp_I > max_q) begin
      max_q <= dp_I;
    end
  end

  assign dp_O = max_q;

endmodule

// File: rtl/maxpool_unit.sv
// Integration of the max-pool controller with its running-maximum datapath.
module maxpool_unit #(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       win_len,
  input  logic [CW-1:0]       win_cnt,
  maxpool_ctrl_if.slave       in_if,
  output logic                out_valid,
  output logic [CW-1:0]       win_idx,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] max_out
);

  logic signed [N-1:0] dp_I;
  logic                max_clr;
  logic                max_pool;

  maxpool_ctrl #(.N(N), .CW(CW)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .win_len   (win_len),
    .win_cnt   (win_cnt),
    .in_if     (in_if),
    .dp_I      (dp_I),
    .max_clr   (max_clr),
    .max_pool  (max_pool),
    .out_valid (out_valid),
    .win_idx   (win_idx),
    .busy      (busy),
    .done      (done)
  );

  maxpool #(.N(N)) u_dp (
    .clk      (clk),
    .dp_I     (dp_I),
    .max_clr  (max_clr),
    .max_pool (max_pool),
    .dp_O     (max_out)
  );

endmodule

// File: rtl/maxpool_ctrl.sv
// Sequencer for a streaming max-pool datapath: splits a job into win_cnt
// windows of win_len elements and steers the datapath load/max mode.
//
// state | meaning
// IDLE  | waiting for start; datapath held cleared
// RUN   | accepting elements of the current window
// LAST  | final window maximum presented; done pulses
module maxpool_ctrl
  import maxpool_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       win_len,
  input  logic [CW-1:0]       win_cnt,
  maxpool_ctrl_if.slave       in_if,
  output logic signed [N-1:0] dp_I,
  output logic                max_clr,
  output logic                max_pool,
  output logic                out_valid,
  output logic [CW-1:0]       win_idx,
  output logic                busy,
  output logic                done
);

  localparam logic signed [N-1:0] MOST_NEG = N'(MOST_NEG_MAXW >> (MAXW - N));

  state_e        state_q, state_d;
  logic [CW-1:0] elem_cnt_q, elem_cnt_d;
  logic [CW-1:0] win_idx_q, win_idx_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;

  logic accept;
  logic last_elem;
  logic last_win;

  assign accept    = in_if.in_valid && (state_q == ST_RUN) && !rst;
  assign last_elem = (elem_cnt_q == len_q - CW'(1));
  assign last_win  = (win_idx_q == cnt_q - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      elem_cnt_q  <= '0;
      win_idx_q   <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_cnt_q  <= elem_cnt_d;
      win_idx_q   <= win_idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_cnt_d  = elem_cnt_q;
    win_idx_d   = win_idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // An empty job completes immediately without touching the datapath.
          if ((win_len != '0) && (win_cnt != '0)) begin
            state_d    = ST_RUN;
            len_d      = win_len;
            cnt_d      = win_cnt;
            elem_cnt_d = '0;
            win_idx_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (last_elem) begin
            elem_cnt_d  = '0;
            out_valid_d = 1'b1;
            if (last_win) begin
              state_d = ST_LAST;
              done_d  = 1'b1;
            end else begin
              win_idx_d = win_idx_q + CW'(1);
            end
          end else begin
            elem_cnt_d = elem_cnt_q + CW'(1);
          end
        end
      end
      ST_LAST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Idle, reset and stall cycles feed MOST_NEG in max mode so the datapath holds.
  always_comb begin
    in_if.in_ready = 1'b0;
    max_clr        = 1'b1;
    max_pool       = 1'b1;
    dp_I           = MOST_NEG;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          in_if.in_ready = 1'b1;
          max_clr        = 1'b0;
          if (accept) begin
            dp_I     = in_if.in_data;
            max_pool = (elem_cnt_q != '0);
          end
        end
        ST_LAST: max_clr = 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign win_idx   = win_idx_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_LAST);

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Bench for maxpool_ctrl: directed jobs plus random jobs against a window-level model.
module tb_maxpool_ctrl;

  localparam int N  = 32;
  localparam int CW = 8;
  localparam logic signed [N-1:0] MNEG = {1'b1, {(N-1){1'b0}}};

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [CW-1:0]       win_len;
  logic [CW-1:0]       win_cnt;
  logic                in_valid;
  logic signed [N-1:0] in_data;

  logic signed [N-1:0] dp_I;
  logic                max_clr, max_pool, out_valid, busy, done;
  logic [CW-1:0]       win_idx;
  logic                u_ov, u_busy, u_done;
  logic [CW-1:0]       u_idx;
  logic signed [N-1:0] u_max;

  maxpool_ctrl_if #(.N(N)) s_if ();
  maxpool_ctrl_if #(.N(N)) u_if ();
  assign s_if.in_valid = in_valid;
  assign s_if.in_data  = in_data;
  assign u_if.in_valid = in_valid;
  assign u_if.in_data  = in_data;

  maxpool_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .win_cnt(win_cnt),
    .in_if(s_if), .dp_I(dp_I), .max_clr(max_clr), .max_pool(max_pool),
    .out_valid(out_valid), .win_idx(win_idx), .busy(busy), .done(done)
  );

  maxpool_unit #(.N(N), .CW(CW)) u_unit (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .win_cnt(win_cnt),
    .in_if(u_if), .out_valid(u_ov), .win_idx(u_idx), .busy(u_busy), .done(u_done),
    .max_out(u_max)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qmax(input int q[$]);
    int m;
    m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  // Window-level model: phase 0 = no job, 1 = streaming, 2 = final result shown.
  bit                  m_known = 1'b0;
  int                  m_phase, m_need, m_wleft, m_len;
  logic [CW-1:0]       m_idx;
  bit                  m_ov, m_done;
  logic signed [N-1:0] m_dpo;
  int                  m_win[$];
  int                  m_res[$];

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1;
      m_phase = 0;
      m_idx   = '0;
      m_ov    = 1'b0;
      m_done  = 1'b0;
      m_dpo   = '0;
      m_win.delete();
    end else if (m_known) begin
      m_ov   = 1'b0;
      m_done = 1'b0;
      case (m_phase)
        0: begin
          m_dpo = '0;
          if (start) begin
            if (win_len != 0 && win_cnt != 0) begin
              m_phase = 1;
              m_len   = int'(win_len);
              m_need  = int'(win_len);
              m_wleft = int'(win_cnt);
              m_idx   = '0;
              m_win.delete();
            end else begin
              m_done = 1'b1;
            end
          end
        end
        1: begin
          if (in_valid) begin
            m_win.push_back(int'(in_data));
            m_dpo = qmax(m_win);
            m_need--;
            if (m_need == 0) begin
              m_ov = 1'b1;
              m_res.push_back(int'(m_dpo));
              m_win.delete();
              m_wleft--;
              if (m_wleft == 0) begin
                m_phase = 2;
                m_done  = 1'b1;
              end else begin
                m_idx++;
                m_need = m_len;
              end
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  int dut_res[$];
  int ov_cyc[$];
  int n_done    = 0;
  int n_done_ov = 0;
  int cyc_n     = 0;

  always @(negedge clk) begin
    logic                e_ready, e_clr, e_pool;
    logic signed [N-1:0] e_dpi;
    #2;
    cyc_n++;
    if (m_known) begin
      e_ready = 1'b0;
      e_clr   = 1'b1;
      e_pool  = 1'b1;
      e_dpi   = MNEG;
      if (!rst) begin
        if (m_phase == 1) begin
          e_ready = 1'b1;
          e_clr   = 1'b0;
          if (in_valid) begin
            e_dpi  = in_data;
            e_pool = (m_win.size() != 0);
          end
        end else if (m_phase == 2) begin
          e_clr = 1'b0;
        end
        chk("dp_I", dp_I, e_dpi);
      end
      chk("in_ready", s_if.in_ready, e_ready);
      chk("max_clr", max_clr, e_clr);
      chk("max_pool", max_pool, e_pool);
      chk("out_valid", out_valid, m_ov);
      chk("done", done, m_done);
      chk("busy", busy, m_phase != 0);
      chk("win_idx", win_idx, m_idx);
      chk("unit max_out", u_max, m_dpo);
      chk("unit out_valid", u_ov, m_ov);
      chk("unit done", u_done, m_done);
      chk("unit busy", u_busy, m_phase != 0);
      chk("unit win_idx", u_idx, m_idx);
      chk("unit in_ready", u_if.in_ready, e_ready);
      if (u_ov === 1'b1) begin
        dut_res.push_back(int'(u_max));
        ov_cyc.push_back(cyc_n);
      end
      if (done === 1'b1) n_done++;
      if (done === 1'b1 && out_valid === 1'b1) n_done_ov++;
    end
  end

  task automatic feed(input bit v, input int d, input bit s = 1'b0);
    in_valid = v;
    in_data  = d;
    start    = s;
    if (s) begin
      win_len = 8'd1;
      win_cnt = 8'd1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) feed(1'b0, 0);
  endtask

  task automatic do_start(input int l, input int c);
    start    = 1'b1;
    win_len  = CW'(l);
    win_cnt  = CW'(c);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    dut_res.delete();
    m_res.delete();
    ov_cyc.delete();
    n_done    = 0;
    n_done_ov = 0;
  endtask

  task automatic check_res(input string nm, input int n, input int a = 0, input int b = 0, input int c = 0);
    int e;
    chk({nm, " result count"}, dut_res.size(), n);
    chk({nm, " model count"}, m_res.size(), n);
    for (int i = 0; i < n; i++) begin
      e = (i == 0) ? a : (i == 1) ? b : c;
      if (i < dut_res.size()) chk({nm, " result"}, dut_res[i], e);
      if (i < m_res.size()) chk({nm, " model result"}, m_res[i], e);
    end
  endtask

  task automatic rand_job(input int l, input int c, input bit allow_rst);
    int budget;
    budget = l * c * 20 + 20;
    do_start(l, c);
    for (int k = 0; k < budget; k++) begin
      if (busy !== 1'b1) break;
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = $urandom;
      if ($urandom_range(0, 3) == 0) in_data = $urandom_range(0, 20) - 10;
      start   = ($urandom_range(0, 7) == 0);
      win_len = CW'($urandom);
      win_cnt = CW'($urandom);
      rst     = allow_rst && ($urandom_range(0, 199) == 0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
    end
    chk("job finished", busy, 0);
    in_valid = 1'b0;
    idle(2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; win_len = '0; win_cnt = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst win_idx", win_idx, 0);
    chk("rst in_ready", s_if.in_ready, 0);
    chk("rst max_clr", max_clr, 1);
    chk("rst max_pool", max_pool, 1);
    chk("rst max_out", u_max, 0);
    rst = 1'b0;
    @(negedge clk);

    clear_logs();
    do_start(3, 2);
    feed(1, 1); feed(1, 9); feed(1, -4); feed(1, -7); feed(1, -2); feed(1, -5);
    idle(3);
    check_res("two windows", 2, 9, -2);
    chk("two windows done count", n_done, 1);
    chk("two windows done with out_valid", n_done_ov, 1);

    clear_logs();
    do_start(4, 1);
    feed(1, 2); feed(0, 0); feed(0, 0); feed(1, 7); feed(0, 0); feed(1, 3); feed(1, 1);
    idle(3);
    check_res("gapped window", 1, 7);

    clear_logs();
    do_start(1, 3);
    feed(1, -3); feed(1, 0); feed(1, 5);
    idle(3);
    check_res("len1", 3, -3, 0, 5);
    chk("len1 consecutive", (ov_cyc.size() == 3) ? ov_cyc[2] - ov_cyc[0] : -1, 2);

    clear_logs();
    do_start(0, 5); idle(3);
    do_start(4, 0); idle(3);
    chk("empty job done count", n_done, 2);
    check_res("empty job", 0);

    clear_logs();
    do_start(4, 1);
    feed(1, 10); feed(1, 20);
    rst = 1'b1;
    feed(0, 0);
    rst = 1'b0;
    chk("mid-job reset busy", busy, 0);
    chk("mid-job reset win_idx", win_idx, 0);
    do_start(2, 1);
    feed(1, 4); feed(1, 6);
    idle(3);
    check_res("restart", 1, 6);

    clear_logs();
    do_start(2, 2);
    feed(1, 3, 1); feed(1, -8, 1); feed(1, -1); feed(1, -6, 1); feed(0, 0, 1);
    idle(3);
    check_res("start while busy", 2, 3, -1);
    chk("start while busy done count", n_done, 1);

    for (int j = 0; j < 40; j++) rand_job($urandom_range(0, 6), $urandom_range(0, 4), 1'b1);
    rand_job(255, 2, 1'b0);
    rand_job(1, 255, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
